// File: rtl/servo_pulse_guard.sv
// Servo PWM guard: clamps pulse high time, measures width, flags lost/stuck input.
// Define SERVO_GUARD_HOLD_EN to regenerate the last clamped pulse while in FAULT.
module servo_pulse_guard #(
    parameter int MIN_HIGH   = 100000,
    parameter int MAX_HIGH   = 200000,
    parameter int PERIOD_MAX = 2500000,
    parameter int PERIOD_NOM = 2000000,
    parameter int CNT_W      = 22
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Pulse_In,
    output logic             Pulse_Out,
    output logic             Fault,
    output logic [1:0]       Fault_Code,
    output logic [CNT_W-1:0] Width,
    output logic             Width_Valid,
    output logic             Clamp
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, FAULT} state_t;

    localparam logic [CNT_W:0]   ONE_C  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   MIN_C  = (CNT_W+1)'(MIN_HIGH);
    localparam logic [CNT_W:0]   MAX_C  = (CNT_W+1)'(MAX_HIGH);
    localparam logic [CNT_W:0]   PMAX_C = (CNT_W+1)'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] PMAX_N = CNT_W'(PERIOD_MAX);

    if ((64'(PERIOD_MAX) >= (64'd1 << CNT_W)) || (MIN_HIGH > MAX_HIGH) ||
        (PERIOD_NOM <= MAX_HIGH)) begin : g_bad_cfg
        $error("servo_pulse_guard: inconsistent parameters");
    end

    state_t           state;
    logic             s1, s, s_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             rise, fall, at_max;

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign cnt_inc = {1'b0, cnt} + ONE_C;
    assign at_max  = cnt_inc >= PMAX_C;
    assign cnt_sat = at_max ? PMAX_N : cnt_inc[CNT_W-1:0];

`ifdef SERVO_GUARD_HOLD_EN
    localparam logic [CNT_W:0]   NOM_C = (CNT_W+1)'(PERIOD_NOM);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_HIGH);

    logic [CNT_W-1:0] hcnt, hold_len;
    logic [CNT_W:0]   hcnt_inc;

    assign hcnt_inc = {1'b0, hcnt} + ONE_C;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s           <= 1'b0;
            s_d         <= 1'b0;
            cnt         <= '0;
            Pulse_Out   <= 1'b0;
            Fault       <= 1'b0;
            Fault_Code  <= 2'b00;
            Width       <= '0;
            Width_Valid <= 1'b0;
            Clamp       <= 1'b0;
`ifdef SERVO_GUARD_HOLD_EN
            hcnt        <= '0;
            hold_len    <= MIN_N;
`endif
        end else begin
            s1          <= Pulse_In;
            s           <= s1;
            s_d         <= s;
            cnt         <= rise ? '0 : cnt_sat;
            Width_Valid <= 1'b0;
            Clamp       <= 1'b0;
            case (state)
                IDLE, LOW: begin
                    if (rise) begin
                        state     <= HIGH;
                        Pulse_Out <= 1'b1;
                    end else if (at_max) begin
                        state      <= FAULT;
                        Fault      <= 1'b1;
                        Fault_Code <= 2'b01;
`ifdef SERVO_GUARD_HOLD_EN
                        hcnt       <= '0;
                        Pulse_Out  <= 1'b1;
`else
                        Pulse_Out  <= 1'b0;
`endif
                    end else begin
                        // stretch a short pulse out to MIN_HIGH
                        Pulse_Out <= Pulse_Out & (cnt_inc < MIN_C);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state       <= LOW;
                        Width       <= cnt_sat;
                        Width_Valid <= 1'b1;
                        Clamp       <= (cnt_inc < MIN_C) | (cnt_inc > MAX_C);
                        Pulse_Out   <= Pulse_Out & (cnt_inc < MIN_C);
`ifdef SERVO_GUARD_HOLD_EN
                        hold_len    <= (cnt_inc < MIN_C) ? MIN_N :
                                       (cnt_inc > MAX_C) ? MAX_N : cnt_sat;
`endif
                    end else if (at_max) begin
                        state      <= FAULT;
                        Fault      <= 1'b1;
                        Fault_Code <= 2'b10;
`ifdef SERVO_GUARD_HOLD_EN
                        hcnt       <= '0;
                        Pulse_Out  <= 1'b1;
`else
                        Pulse_Out  <= 1'b0;
`endif
                    end else begin
                        Pulse_Out <= Pulse_Out & (cnt_inc < MAX_C);
                    end
                end
                FAULT: begin
                    if (rise) begin
                        state     <= HIGH;
                        Fault     <= 1'b0;
                        Pulse_Out <= 1'b1;
                    end else begin
`ifdef SERVO_GUARD_HOLD_EN
                        if (hcnt_inc >= NOM_C) begin
                            hcnt      <= '0;
                            Pulse_Out <= 1'b1;
                        end else begin
                            hcnt      <= hcnt_inc[CNT_W-1:0];
                            Pulse_Out <= hcnt_inc < {1'b0, hold_len};
                        end
`else
                        Pulse_Out <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pulse_guard.sv
// Randomized bench for servo_pulse_guard against an event-level reference model.
// Default build only (SERVO_GUARD_HOLD_EN undefined).
module tb_servo_pulse_guard;

    localparam int MINH = 10;
    localparam int MAXH = 20;
    localparam int PMAX = 100;
    localparam int NOM  = 50;
    localparam int W    = 8;

    logic         sysclk = 1'b0;
    logic         reset = 1'b1;
    logic         Pulse_In = 1'b0;
    logic         Pulse_Out, Fault, Width_Valid, Clamp;
    logic [1:0]   Fault_Code;
    logic [W-1:0] Width;

    servo_pulse_guard #(
        .MIN_HIGH(MINH), .MAX_HIGH(MAXH), .PERIOD_MAX(PMAX),
        .PERIOD_NOM(NOM), .CNT_W(W)
    ) dut (
        .sysclk(sysclk), .reset(reset), .Pulse_In(Pulse_In),
        .Pulse_Out(Pulse_Out), .Fault(Fault), .Fault_Code(Fault_Code),
        .Width(Width), .Width_Valid(Width_Valid), .Clamp(Clamp)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model state: edge index since reset release, last rise edge,
    // whether that pulse has already ended, and sticky outputs.
    int       e, r, width, code;
    bit       have_r, fell;
    bit [3:0] hist;

    task automatic model_reset();
        e = 0; r = 0; width = 0; code = 0;
        have_r = 0; fell = 0; hist = '0;
    endtask

    task automatic step(input bit v);
        bit rise, fall, valid, clmp, exp_fault, exp_pout;
        int age;
        Pulse_In = v;
        @(posedge sysclk);
        #1;
        e++;
        hist  = {hist[2:0], v};
        // input level seen before edge k acts as rise/fall at edge k+2
        rise  = hist[2] & ~hist[3];
        fall  = ~hist[2] & hist[3];
        valid = 0;
        clmp  = 0;
        if (rise) begin
            r = e; have_r = 1; fell = 0;
        end else if (fall && have_r && !fell && (e - r) < PMAX) begin
            width = e - r;
            valid = 1;
            clmp  = (width < MINH) || (width > MAXH);
            fell  = 1;
        end
        age = have_r ? e - r : e;
        if (!rise && age == PMAX) code = (have_r && !fell) ? 2 : 1;
        exp_fault = age >= PMAX;
        exp_pout  = have_r && (age < MINH || (!fell && age < MAXH));
        check("pulse_out", Pulse_Out, exp_pout);
        check("fault", Fault, exp_fault);
        check("fault_code", Fault_Code, code);
        check("width", Width, width);
        check("width_valid", Width_Valid, valid);
        check("clamp", Clamp, clmp);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_pulse_out"}, Pulse_Out, 0);
        check({pfx, "_fault"}, Fault, 0);
        check({pfx, "_code"}, Fault_Code, 0);
        check({pfx, "_width"}, Width, 0);
        check({pfx, "_valid"}, Width_Valid, 0);
        check({pfx, "_clamp"}, Clamp, 0);
    endtask

    initial begin
        int hi, lo;
        repeat (3) @(posedge sysclk);
        #1;
        check_zero("rst");
        reset = 1'b0;
        model_reset();

        repeat (3) pulse(15, 45);
        pulse(4, 40);
        pulse(35, 40);
        pulse(15, 130);
        pulse(12, 40);
        pulse(130, 30);
        pulse(15, 45);
        pulse(3, 2);
        pulse(5, 1);
        pulse(25, 50);

        repeat (40) begin
            hi = $urandom_range(1, 40);
            lo = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 130)
                                              : $urandom_range(1, 60);
            pulse(hi, lo);
        end

        pulse(15, 40);
        repeat (11) step(1'b1);
        #3;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        repeat (3) @(posedge sysclk);
        #1;
        Pulse_In = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (110) step(1'b0);
        pulse(15, 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
